// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch path: widths, the filler
// instruction value returned for unmapped addresses, FSM states and queue entries.
package fetch_pkg;

  localparam int          ADDR_W        = 32;
  localparam logic [31:0] INVALID_INSTR = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FAULT = 2'd3
  } fsm_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small circular FIFO of fetched {pc, instr} entries. Flush empties it in one
// cycle and overrides any push or pop presented in the same cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int   DEPTH = 2,
  localparam int  CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output fetch_entry_t     head,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: state flops use non-blocking assignment so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; count_q alone decides which slots are meaningful.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, issues one read per cycle to a
// 1-cycle-latency memory, queues returns for decode and handles redirects/faults.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int          MEM_SIZE    = 1024,
  parameter logic [31:0] RESET_PC    = 32'd0,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        busy,
  output logic        fault,
  output logic [31:0] fault_pc
);

  localparam int                CNT_W     = $clog2(QUEUE_DEPTH + 1);
  localparam int                SUM_W     = CNT_W + 1;
  localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(MEM_SIZE);

  fsm_state_e        state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic [ADDR_W-1:0] fault_pc_q, fault_pc_d;
  logic              inflight_q, inflight_d;

  logic              q_push, q_pop, q_flush, q_empty, q_full;
  logic [CNT_W-1:0]  q_count;
  fetch_entry_t      q_head, q_push_data;
  logic              in_range, credit_ok, issue_en;

  assign in_range = (fetch_pc_q < MEM_LIMIT);
  assign q_pop    = out_valid & out_ready;
  // Credit: entries held plus the one in flight, minus the one leaving now, must leave room.
  assign credit_ok = (SUM_W'(q_count) + SUM_W'(inflight_q)) <
                     (SUM_W'(QUEUE_DEPTH) + SUM_W'(q_pop));
  assign issue_en  = (state_q == ST_RUN) && in_range && credit_ok && !redirect_valid;

  assign q_flush     = redirect_valid;
  assign q_push      = inflight_q;
  assign q_push_data = '{pc: req_pc_q, instr: imem_data};

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    fault_pc_d = fault_pc_q;
    inflight_d = 1'b0;
    if (redirect_valid) begin
      state_d    = ST_RUN;
      fetch_pc_d = redirect_pc;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d    = ST_RUN;
            fetch_pc_d = RESET_PC;
          end
        end
        ST_RUN: begin
          if (!in_range) begin
            fault_pc_d = fetch_pc_q;
            state_d    = ST_DRAIN;
          end else if (issue_en) begin
            inflight_d = 1'b1;
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd1;
          end
        end
        ST_DRAIN: begin
          if (!inflight_q && q_empty) state_d = ST_FAULT;
        end
        ST_FAULT: begin
          if (start) begin
            state_d    = ST_RUN;
            fetch_pc_d = RESET_PC;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      fault_pc_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      fault_pc_q <= fault_pc_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (q_push),
    .push_data (q_push_data),
    .pop       (q_pop),
    .flush     (q_flush),
    .count     (q_count),
    .head      (q_head),
    .empty     (q_empty),
    .full      (q_full)
  );

  no_push_when_full_a: assert property (@(posedge clk) disable iff (rst)
    (q_push && !q_flush) |-> !q_full);

  assign imem_addr = fetch_pc_q;
  assign out_valid = ~q_empty;
  assign out_instr = q_empty ? '0 : q_head.instr;
  assign out_pc    = q_empty ? '0 : q_head.pc;
  assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign fault     = (state_q == ST_FAULT);
  assign fault_pc  = fault_pc_q;

endmodule
